// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller with solid all-zeros / all-ones backgrounds.
// Runs six elements (w0 up; r0w1 up; r1w0 up; r0w1 down; r1w0 down; r0 up)
// and records mismatch status (sticky flag, first failing address, saturating count).
//
// state | meaning
// IDLE  | waiting for start, memory port quiet
// WRITE | E0 initialisation write, one address per cycle
// READ  | read issued for current element/address
// CMP   | read data checked; E1-E4 also write the new background here
// DONE  | run finished, results held until next start or rst
module mbist_march_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_SIZE   = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [7:0]            fail_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      CMP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [2:0]            E_FINAL   = 3'd5;

   state_t                  state, state_nxt;
   logic [2:0]              elem, elem_nxt;
   logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
   logic                    fail_nxt;
   logic [ADDR_WIDTH-1:0]   fail_addr_nxt;
   logic [7:0]              fail_count_nxt;

   logic                    elem_down;
   logic                    next_elem_down;
   logic                    last_addr;
   logic                    wr_bg;
   logic                    rd_bg;
   logic                    mismatch;

   // Element attributes: direction, backgrounds, end-of-element detect, compare result
   always_comb begin
      elem_down      = (elem == 3'd3) || (elem == 3'd4);
      next_elem_down = (elem == 3'd2) || (elem == 3'd3);
      last_addr      = elem_down ? (addr == '0) : (addr == LAST_ADDR);
      wr_bg          = (elem == 3'd1) || (elem == 3'd3);
      rd_bg          = (elem == 3'd2) || (elem == 3'd4);
      mismatch       = (state == CMP) && (mem_rdata != {DATA_WIDTH{rd_bg}});
   end

   // State register and run bookkeeping; rst wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         elem       <= '0;
         addr       <= '0;
         fail       <= 1'b0;
         fail_addr  <= '0;
         fail_count <= '0;
      end else begin
         state      <= state_nxt;
         elem       <= elem_nxt;
         addr       <= addr_nxt;
         fail       <= fail_nxt;
         fail_addr  <= fail_addr_nxt;
         fail_count <= fail_count_nxt;
      end
   end

   // Next-state sequencing, mismatch capture and memory port drive
   always_comb begin
      state_nxt      = state;
      elem_nxt       = elem;
      addr_nxt       = addr;
      fail_nxt       = fail;
      fail_addr_nxt  = fail_addr;
      fail_count_nxt = fail_count;
      mem_en         = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      busy           = 1'b0;
      done           = 1'b0;

      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               state_nxt      = WRITE;
               elem_nxt       = '0;
               addr_nxt       = '0;
               fail_nxt       = 1'b0;
               fail_addr_nxt  = '0;
               fail_count_nxt = '0;
            end
         end

         WRITE: begin
            busy     = 1'b1;
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = addr;
            if (last_addr) begin
               state_nxt = READ;
               elem_nxt  = 3'd1;
               addr_nxt  = '0;
            end else begin
               addr_nxt  = addr + ADDR_ONE;
            end
         end

         READ: begin
            busy      = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = addr;
            state_nxt = CMP;
         end

         CMP: begin
            busy = 1'b1;
            // The final element is read-only, so its compare cycle leaves the port quiet
            if (elem != E_FINAL) begin
               mem_en    = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = addr;
               mem_wdata = {DATA_WIDTH{wr_bg}};
            end
            if (mismatch) begin
               fail_nxt = 1'b1;
               if (!fail)
                  fail_addr_nxt = addr;
               if (fail_count != 8'hff)
                  fail_count_nxt = fail_count + 8'd1;
            end
            if (last_addr) begin
               if (elem == E_FINAL) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = READ;
                  elem_nxt  = elem + 3'd1;
                  addr_nxt  = next_elem_down ? LAST_ADDR : '0;
               end
            end else begin
               state_nxt = READ;
               addr_nxt  = elem_down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: synchronous memory with stuck-at fault masks,
// table-driven March C- reference producing the expected access trace and results.
module tb_mbist_march_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 16;
   localparam int TW = AW + DW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_addr;
   logic [7:0]    fail_count;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem_arr [N];
   logic [DW-1:0] sa0     [N];
   logic [DW-1:0] sa1     [N];

   logic [TW-1:0] exp_trace [$];
   logic          exp_fail;
   int            exp_first;
   int            exp_count;

   // March C- as a table: direction (1 = down), read background (-1 none), write background (-1 none)
   int el_dir [6] = '{0, 0, 0, 1, 1, 0};
   int el_rd  [6] = '{-1, 0, 1, 0, 1, 0};
   int el_wr  [6] = '{0, 1, 0, 1, 0, -1};

   mbist_march_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_SIZE   (N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_count (fail_count)
   );

   always #5 clk = ~clk;

   // Synchronous memory; read data is garbage except the cycle after a read
   always @(posedge clk) begin
      if (mem_en && mem_we && (int'(mem_addr) < N))
         mem_arr[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we && (int'(mem_addr) < N))
         mem_rdata <= (mem_arr[mem_addr] & ~sa0[mem_addr]) | sa1[mem_addr];
      else
         mem_rdata <= DW'($urandom);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < N; i++) begin
         sa0[i] = '0;
         sa1[i] = '0;
      end
   endtask

   // Walk the element table to get the per-cycle access trace and fault results
   task automatic build_expected();
      logic [DW-1:0] m [N];
      logic [DW-1:0] bg;
      logic [DW-1:0] v;
      int a;
      exp_trace.delete();
      exp_fail  = 1'b0;
      exp_first = 0;
      exp_count = 0;
      for (int i = 0; i < N; i++) m[i] = DW'($urandom);
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            a = (el_dir[e] == 1) ? (N - 1 - i) : i;
            if (el_rd[e] >= 0) begin
               bg = (el_rd[e] == 1) ? '1 : '0;
               exp_trace.push_back({1'b1, 1'b0, AW'(a), {DW{1'b0}}});
               v = (m[a] & ~sa0[a]) | sa1[a];
               if (v != bg) begin
                  if (!exp_fail) exp_first = a;
                  exp_fail = 1'b1;
                  if (exp_count < 255) exp_count++;
               end
            end
            if (el_wr[e] >= 0) begin
               bg = (el_wr[e] == 1) ? '1 : '0;
               exp_trace.push_back({1'b1, 1'b1, AW'(a), bg});
               m[a] = bg;
            end else begin
               exp_trace.push_back('0);
            end
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, "_en"},   32'(mem_en),     32'd0);
      check_val({tag, "_we"},   32'(mem_we),     32'd0);
      check_val({tag, "_addr"}, 32'(mem_addr),   32'd0);
      check_val({tag, "_wd"},   32'(mem_wdata),  32'd0);
      check_val({tag, "_busy"}, 32'(busy),       32'd0);
      check_val({tag, "_done"}, 32'(done),       32'd0);
      check_val({tag, "_fail"}, 32'(fail),       32'd0);
      check_val({tag, "_fadr"}, 32'(fail_addr),  32'd0);
      check_val({tag, "_fcnt"}, 32'(fail_count), 32'd0);
   endtask

   // One run: start pulse, per-cycle trace compare, final result compare.
   // stray_at pulses start mid-run; rst_at aborts the run with rst.
   task automatic run_march(input int stray_at, input int rst_at);
      logic [TW-1:0] got;
      build_expected();
      check_val("trace_len", 32'(exp_trace.size()), 32'(11 * N));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 11 * N; k++) begin
         if (k == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            check_quiet("rst_mid");
            @(negedge clk);
            rst = 1'b0;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               check_quiet("post_rst");
            end
            return;
         end
         got = {mem_en, mem_we, mem_addr, mem_wdata};
         if (exp_trace[k][TW-1])
            check_val("trace", 32'(got), 32'(exp_trace[k]));
         else
            check_val("trace_en", 32'(mem_en), 32'd0);
         check_val("busy", 32'(busy), 32'd1);
         if (k == 0) begin
            check_val("done_clr", 32'(done), 32'd0);
            check_val("fail_clr", 32'(fail), 32'd0);
            check_val("fcnt_clr", 32'(fail_count), 32'd0);
         end
         start = (k == stray_at);
         @(negedge clk);
      end
      start = 1'b0;
      check_val("done",      32'(done),       32'd1);
      check_val("busy_end",  32'(busy),       32'd0);
      check_val("en_end",    32'(mem_en),     32'd0);
      check_val("fail",      32'(fail),       32'(exp_fail));
      check_val("fail_addr", 32'(fail_addr),  32'(exp_first));
      check_val("fail_cnt",  32'(fail_count), 32'(exp_count));
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      clear_faults();
      for (int i = 0; i < N; i++) mem_arr[i] = '0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      start = 1'b1;
      @(negedge clk);
      check_quiet("start_in_rst");
      rst   = 1'b0;
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check_quiet("idle");
      end

      // Fault-free, with a stray start while busy
      run_march(37, -1);
      check_val("clean_cnt", 32'(fail_count), 32'd0);

      // Stuck-at-0 bit 2 at address 5
      clear_faults();
      sa0[5] = 8'h04;
      run_march(-1, -1);
      check_val("sa0_fail", 32'(fail), 32'd1);
      check_val("sa0_addr", 32'(fail_addr), 32'd5);
      check_val("sa0_cnt",  32'(fail_count), 32'd2);

      // Stuck-at-1 bit 0 at address 0
      clear_faults();
      sa1[0] = 8'h01;
      run_march(120, -1);
      check_val("sa1_addr", 32'(fail_addr), 32'd0);
      check_val("sa1_cnt",  32'(fail_count), 32'd3);

      // First fault at 9 (seen in E1), second at 3 (seen in E2)
      clear_faults();
      sa1[9] = 8'h80;
      sa0[3] = 8'h10;
      run_march(-1, -1);
      check_val("two_addr", 32'(fail_addr), 32'd9);
      check_val("two_cnt",  32'(fail_count), 32'd5);

      // Restart from DONE after a failing run
      clear_faults();
      run_march(-1, -1);

      // Reset in the middle of E3, then a full rerun
      sa1[2] = 8'h02;
      run_march(-1, 5 * N + 10);
      clear_faults();
      run_march(-1, -1);

      // Random fault sets
      for (int it = 0; it < 8; it++) begin
         clear_faults();
         for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
            int a;
            a = int'($urandom_range(0, N - 1));
            sa0[a] = DW'($urandom);
            sa1[a] = DW'($urandom) & ~sa0[a];
         end
         run_march(int'($urandom_range(0, 11 * N + 20)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
- REQ-001: Parameter ADDR_WIDTH, default 8, address bus width.
- REQ-002: Parameter DATA_WIDTH, default 8, data bus width.
- REQ-003: Parameter MEM_SIZE, default 256, number of addresses tested; legal range 2..2**ADDR_WIDTH.
- REQ-004: One clock; reset is synchronous and active-high. Ports: clk input 1, the single clock; rst input 1, synchronous active-high reset.
- REQ-005: start input 1, one-cycle request to run the test.
- REQ-006: mem_en output 1, memory access enable.
- REQ-007: mem_we output 1, write enable; 0 with mem_en=1 means read.
- REQ-008: mem_addr output ADDR_WIDTH, access address.
- REQ-009: mem_wdata output DATA_WIDTH, write data.
- REQ-010: mem_rdata input DATA_WIDTH, read data, valid the cycle after a read is sampled.
- REQ-011: busy output 1, test in progress.
- REQ-012: done output 1, test complete; held until the next accepted start or rst.
- REQ-013: fail output 1, sticky: at least one read mismatch.
- REQ-014: fail_addr output ADDR_WIDTH, address of the first mismatch.
- REQ-015: fail_count output 8, mismatch count, saturating at 255.

Function
- REQ-016: The test SHALL run March C- with solid backgrounds (0 = all-zeros word, 1 = all-ones word) as six elements:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- REQ-017: "Up" SHALL mean address 0 to MEM_SIZE-1; "down" SHALL mean MEM_SIZE-1 to 0. No address >= MEM_SIZE SHALL ever be driven.
- REQ-018: States SHALL be IDLE, WRITE, READ, CMP, DONE.
- REQ-019: start in IDLE or DONE SHALL:
  - clear done, fail, fail_addr and fail_count;
  - assert busy;
  - enter element E0 at the next edge.
- REQ-020: start while busy SHALL be ignored.
- REQ-021: WRITE (E0) SHALL drive mem_en=1, mem_we=1 and mem_wdata=background for 1 cycle per address.
- REQ-022: READ SHALL drive mem_en=1, mem_we=0 for 1 cycle, then go to CMP.
- REQ-023: CMP SHALL compare mem_rdata with the full expected background word.
- REQ-024: In E1-E4, the CMP cycle SHALL simultaneously drive the element's write (mem_en=1, mem_we=1, same address), giving 2 cycles per address.
- REQ-025: In E5, CMP SHALL drive mem_en=0.
- REQ-026: After the last address of an element, the next element SHALL start at the next edge with no idle cycle.
- REQ-027: Total run time SHALL be 11*MEM_SIZE cycles: done=1 and busy=0 exactly 11*MEM_SIZE edges after the edge that sampled start.
- REQ-028: On a mismatch:
  - fail SHALL be set;
  - fail_count SHALL increment and saturate at 255;
  - fail_addr SHALL load the address only if fail was previously 0.
- REQ-029: The test SHALL always run to completion; it does not abort on fail.
- REQ-030: When not in WRITE, READ or CMP, mem_en SHALL be 0 and mem_we, mem_addr and mem_wdata SHALL be 0.
- REQ-031: Only mem_rdata sampled in a CMP cycle SHALL be used; mem_rdata in any other cycle SHALL be ignored.

Reset
- REQ-032: rst SHALL take priority over start and all activity at any cycle, including mid-element.
- REQ-033: After rst: state IDLE and all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr, fail_count).
- REQ-034: After rst is released, no memory access SHALL occur until a new start.

Verification
- REQ-035: MEM_SIZE=16, fault-free synchronous memory model, pulse start -> done=1 after exactly 176 cycles, fail=0, fail_count=0; the access trace matches REQ-016 order.
- REQ-036: Stuck-at-0 on bit 2 of address 5 -> fail=1, fail_addr=5, fail_count=2 (E2 and E4 r1 reads).
- REQ-037: Stuck-at-1 on bit 0 of address 0 -> fail=1, fail_addr=0, fail_count=3 (E1, E3, E5 r0 reads).
- REQ-038: Two faults: first at address 9 in E1, second at address 3 in E2 -> fail_addr=9; fail_count equals the total mismatches.
- REQ-039: rst asserted mid-E3 -> next cycle all outputs 0, mem_en=0 and held while idle; a new start reruns the full 176 cycles.
- REQ-040: start pulsed during busy -> no effect on the trace; start in DONE after a failing run -> done, fail and fail_count clear and the run restarts.
